// File: rtl/accel_pkg.sv
// Shared constants, FSM encoding and overflow helper for the dot-product datapath.
package accel_pkg;

  localparam int PROD_W    = 16;
  localparam int ACC_W_DEF = 32;
  localparam int CNT_W_DEF = 8;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } acc_state_e;

  // Two's-complement add overflows only when both operands agree in sign and the result does not.
  function automatic logic add_ovf(input logic a_sign, input logic b_sign, input logic r_sign);
    return (a_sign == b_sign) && (r_sign != a_sign);
  endfunction

endpackage

// File: rtl/dot_acc_add.sv
// Combinational accumulate step: sign-extends the product, adds, flags signed overflow.
// With DOT_ACC_SAT_EN defined an overflowing sum clamps to the signed limits; otherwise it wraps.
module dot_acc_add
  import accel_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic signed [ACC_W-1:0]  acc_i,
  input  logic signed [PROD_W-1:0] prod_i,
  output logic signed [ACC_W-1:0]  sum_o,
  output logic                     ovf_o
);

  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] raw_sum;

  assign prod_ext = {{(ACC_W-PROD_W){prod_i[PROD_W-1]}}, prod_i};
  assign raw_sum  = acc_i + prod_ext;
  assign ovf_o    = add_ovf(acc_i[ACC_W-1], prod_ext[ACC_W-1], raw_sum[ACC_W-1]);

`ifdef DOT_ACC_SAT_EN
  localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  // On overflow both operands share a sign, so the accumulator sign picks the rail.
  always_comb begin
    sum_o = raw_sum;
    if (ovf_o) begin
      sum_o = acc_i[ACC_W-1] ? SAT_MIN : SAT_MAX;
    end
  end
`else
  assign sum_o = raw_sum;
`endif

endmodule

// File: rtl/dot_accumulator.sv
// Streams signed 16-bit products into a signed accumulator; in_last latches the result for handoff.
// Latency 1 cycle from last beat to out_valid; in HOLD input is stalled until out_ready. Optional macro: DOT_ACC_SAT_EN.
module dot_accumulator
  import accel_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [PROD_W-1:0] in_prod,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0]  out_acc,
  output logic [CNT_W-1:0]         out_count,
  output logic                     out_ovf
);

  acc_state_e              state_q;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    ovf_q, ovf_d;
  logic                    add_ovf_w;
  logic signed [ACC_W-1:0] out_acc_q;
  logic [CNT_W-1:0]        out_count_q;
  logic                    out_ovf_q;

  dot_acc_add #(
    .ACC_W (ACC_W)
  ) u_add (
    .acc_i  (acc_q),
    .prod_i (in_prod),
    .sum_o  (acc_d),
    .ovf_o  (add_ovf_w)
  );

  assign cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
  assign ovf_d = ovf_q | add_ovf_w;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_acc_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_ACCUM: begin
          if (in_valid) begin
            if (in_last) begin
              // Partial state is kept until handoff and cleared when the result is taken.
              out_acc_q   <= acc_d;
              out_count_q <= cnt_d;
              out_ovf_q   <= ovf_d;
              state_q     <= ST_HOLD;
            end else begin
              acc_q <= acc_d;
              cnt_q <= cnt_d;
              ovf_q <= ovf_d;
            end
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            state_q <= ST_ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
          end
        end
        default: state_q <= ST_ACCUM;
      endcase
    end
  end

  assign in_ready  = (state_q == ST_ACCUM);
  assign out_valid = (state_q == ST_HOLD);
  assign out_acc   = out_acc_q;
  assign out_count = out_count_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_dot_accumulator.sv
// Directed and randomized bench for dot_accumulator (ACC_W=17, CNT_W=2) against an arithmetic reference model.
module tb_dot_accumulator;

  localparam int AW = 17;
  localparam int CW = 2;
  localparam longint MAXV = (longint'(1) << (AW-1)) - 1;
  localparam longint MINV = -(longint'(1) << (AW-1));
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic out_ready = 1'b0;
  logic signed [15:0] in_prod = '0;
  wire in_ready, out_valid, out_ovf;
  wire signed [AW-1:0] out_acc;
  wire [CW-1:0] out_count;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: true partial sum (after wrap/clamp), beat count, sticky overflow, and held result.
  bit     m_hold = 0;
  longint m_acc = 0;
  int     m_cnt = 0;
  bit     m_ovf = 0;
  longint e_acc = 0;
  int     e_cnt = 0;
  bit     e_ovf = 0;

  dot_accumulator #(.ACC_W(AW), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_prod   (in_prod),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_acc   (out_acc),
    .out_count (out_count),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic longint wrapv(input longint s);
    longint m = longint'(1) << AW;
    longint r = s % m;
    if (r < 0) r += m;
    if (r > MAXV) r -= m;
    return r;
  endfunction

  task automatic model_beat(input longint p, input bit last);
    longint s = m_acc + p;
    if (s > MAXV || s < MINV) begin
      m_ovf = 1;
`ifdef DOT_ACC_SAT_EN
      m_acc = (s > MAXV) ? MAXV : MINV;
`else
      m_acc = wrapv(s);
`endif
    end else begin
      m_acc = s;
    end
    if (m_cnt < CMAX) m_cnt++;
    if (last) begin
      e_acc = m_acc; e_cnt = m_cnt; e_ovf = m_ovf; m_hold = 1;
    end
  endtask

  task automatic observe();
    chk("in_ready", longint'(in_ready), longint'(!m_hold));
    chk("out_valid", longint'(out_valid), longint'(m_hold));
    if (m_hold) begin
      chk("out_acc", longint'(out_acc), e_acc);
      chk("out_count", longint'(out_count), longint'(e_cnt));
      chk("out_ovf", longint'(out_ovf), longint'(e_ovf));
    end
  endtask

  // One clock: check state as of this negedge, then drive inputs for the next rising edge.
  task automatic cyc(input bit v, input longint p, input bit last, input bit ordy);
    @(negedge clk);
    observe();
    in_valid = v; in_prod = p[15:0]; in_last = last; out_ready = ordy;
    if (!m_hold) begin
      if (v) model_beat(longint'($signed(p[15:0])), last);
    end else if (ordy) begin
      m_hold = 0; m_acc = 0; m_cnt = 0; m_ovf = 0;
    end
  endtask

  task automatic do_rst(input bit v);
    @(negedge clk);
    rst = 1; in_valid = v; in_prod = 16'sd100; in_last = 0; out_ready = 0;
    m_hold = 0; m_acc = 0; m_cnt = 0; m_ovf = 0;
    @(negedge clk);
    rst = 0; in_valid = 0;
    chk("rst_in_ready", longint'(in_ready), 1);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_out_acc", longint'(out_acc), 0);
    chk("rst_out_count", longint'(out_count), 0);
    chk("rst_out_ovf", longint'(out_ovf), 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    do_rst(0);

    // Mixed-sign vector; count saturates at 3 with a 2-bit counter.
    cyc(1, 10, 0, 0); cyc(1, 1, 0, 0); cyc(1, -127, 0, 0); cyc(1, -128, 0, 0); cyc(1, 25, 1, 0);
    cyc(0, 0, 0, 0);
    chk("vec_acc", longint'(out_acc), -219);
    chk("vec_count", longint'(out_count), 3);
    chk("vec_ovf", longint'(out_ovf), 0);
    cyc(0, 0, 0, 1);

    // Single-beat vector.
    cyc(1, 1, 1, 0);
    cyc(0, 0, 0, 1);
    chk("single_acc", longint'(out_acc), 1);
    chk("single_count", longint'(out_count), 1);
    cyc(0, 0, 0, 0);
    chk("single_release_rdy", longint'(in_ready), 1);

    // Backpressure: beats offered during HOLD must be ignored.
    cyc(1, -7, 1, 0);
    repeat (4) cyc(1, 77, 0, 0);
    cyc(1, 77, 0, 1);
    cyc(1, 3, 1, 0);
    cyc(0, 0, 0, 0);
    chk("bp_next_acc", longint'(out_acc), 3);
    chk("bp_next_count", longint'(out_count), 1);
    cyc(0, 0, 0, 1);

    // Overflow at 17 bits.
    for (int i = 0; i < 5; i++) cyc(1, 16384, (i == 4), 0);
    cyc(0, 0, 0, 0);
    chk("ovf_flag", longint'(out_ovf), 1);
`ifdef DOT_ACC_SAT_EN
    chk("ovf_acc", longint'(out_acc), 65535);
`else
    chk("ovf_acc", longint'(out_acc), -49152);
`endif
    cyc(0, 0, 0, 1);

    // Reset mid-vector with a beat offered in the reset cycle.
    for (int i = 0; i < 3; i++) cyc(1, 100, 0, 0);
    do_rst(1);
    cyc(1, 5, 1, 0);
    cyc(0, 0, 0, 0);
    chk("rst_vec_acc", longint'(out_acc), 5);
    chk("rst_vec_count", longint'(out_count), 1);
    cyc(0, 0, 0, 1);

    // Count saturation.
    for (int i = 0; i < 6; i++) cyc(1, 0, (i == 5), 0);
    cyc(0, 0, 0, 0);
    chk("sat_count", longint'(out_count), 3);
    chk("sat_acc", longint'(out_acc), 0);
    cyc(0, 0, 0, 1);

    // Randomized traffic, including reset in arbitrary states.
    for (int i = 0; i < 1500; i++) begin
      logic signed [15:0] r;
      r = 16'($urandom);
      if ($urandom_range(0, 99) == 0) begin
        do_rst(1'($urandom_range(0, 1)));
      end else begin
        cyc(($urandom_range(0, 3) != 0), longint'(r), ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 2) != 0));
      end
    end
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
